// File: rtl/l2_tcdm_fill_check_pkg.sv
// Shared types and widths for the TCDM fill/check engine.
package l2_tcdm_fill_check_pkg;

    localparam int unsigned ADDR_WIDTH     = 32;
    localparam int unsigned LEN_WIDTH      = 16;
    localparam int unsigned MISMATCH_WIDTH = 16;

    // Command opcode; the encoding doubles as the TCDM wen value.
    typedef enum logic {
        OP_FILL  = 1'b0,
        OP_CHECK = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/l2_tcdm_fill_check_if.sv
// TCDM initiator bus; signal names are seen from the initiator side.
interface l2_tcdm_fill_check_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    import l2_tcdm_fill_check_pkg::*;

    logic                    req_o;
    logic [ADDR_WIDTH-1:0]   add_o;
    logic                    wen_o;
    logic [DATA_WIDTH/8-1:0] be_o;
    logic [DATA_WIDTH-1:0]   wdata_o;
    logic                    gnt_i;
    logic                    r_valid_i;
    logic [DATA_WIDTH-1:0]   r_rdata_i;
    logic                    r_opc_i;

    modport master (
        output req_o, add_o, wen_o, be_o, wdata_o,
        input  gnt_i, r_valid_i, r_rdata_i, r_opc_i
    );

    modport slave (
        input  req_o, add_o, wen_o, be_o, wdata_o,
        output gnt_i, r_valid_i, r_rdata_i, r_opc_i
    );

endinterface

// File: rtl/l2_tcdm_fill_check_outstanding_cnt.sv
// Counts granted beats still waiting for their response; never underflows.
module tcdm_outstanding_cnt #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o,
    output logic                 full_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 dec_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_WIDTH'(MAX_OUTSTANDING));
    assign dec_ok  = dec_i && !empty_o;
    assign cnt_o   = cnt_q;

    // Next count: simultaneous grant and response cancel out.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({inc_i, dec_ok})
            2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
            2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/l2_tcdm_fill_check.sv
// Fills a TCDM word range with a pattern or reads it back and compares,
// keeping a mismatch count and a rotate/XOR signature of the read data.
module l2_tcdm_fill_check
    import l2_tcdm_fill_check_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      op_i,
    input  logic [ADDR_WIDTH-1:0]     base_addr_i,
    input  logic [LEN_WIDTH-1:0]      len_i,
    input  logic [DATA_WIDTH-1:0]     pattern_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [MISMATCH_WIDTH-1:0] mismatch_cnt_o,
    output logic [DATA_WIDTH-1:0]     signature_o,
    l2_tcdm_fill_check_if.master      tcdm
);

    localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

    state_e                    state_q, state_d;
    op_e                       op_q;
    logic [ADDR_WIDTH-1:0]     add_q;
    logic [LEN_WIDTH-1:0]      rem_q;
    logic [DATA_WIDTH-1:0]     pattern_q;
    logic [MISMATCH_WIDTH-1:0] mismatch_q;
    logic [DATA_WIDTH-1:0]     sig_q;
    logic                      err_q;

    logic                      req;
    logic                      beat;
    logic                      start_acc;
    logic                      rsp_check;
    logic                      drain_done;
    logic [CNT_WIDTH-1:0]      outst_cnt;
    logic                      outst_empty;
    logic                      outst_full;

    function automatic logic [DATA_WIDTH-1:0] rotl1(input logic [DATA_WIDTH-1:0] v);
        return {v[DATA_WIDTH-2:0], v[DATA_WIDTH-1]};
    endfunction

    tcdm_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_WIDTH       (CNT_WIDTH)
    ) i_outstanding_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (beat),
        .dec_i   (tcdm.r_valid_i),
        .cnt_o   (outst_cnt),
        .empty_o (outst_empty),
        .full_o  (outst_full)
    );

    assign start_acc  = start_i && (state_q == ST_IDLE);
    assign beat       = req && tcdm.gnt_i;
    // A response arriving in the same cycle as the last outstanding one empties the counter.
    assign drain_done = outst_empty || ((outst_cnt == CNT_ONE) && tcdm.r_valid_i);
    assign rsp_check  = tcdm.r_valid_i && (op_q == OP_CHECK)
                        && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = (len_i == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (beat && (rem_q == LEN_WIDTH'(1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; a response in the full cycle frees a slot immediately so a
    // 1-cycle-latency slave sustains one beat per cycle.
    always_comb begin
        req    = (state_q == ST_ISSUE) && (!outst_full || tcdm.r_valid_i);
        busy_o = (state_q != ST_IDLE);
        done_o = (state_q == ST_DONE);
    end

    // Command latch and address/remaining-count walk.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q      <= OP_CHECK;
            add_q     <= '0;
            rem_q     <= '0;
            pattern_q <= '0;
        end else if (start_acc) begin
            op_q      <= op_e'(op_i);
            add_q     <= base_addr_i;
            rem_q     <= len_i;
            pattern_q <= pattern_i;
        end else if (beat) begin
            add_q     <= add_q + ADDR_STEP;
            rem_q     <= rem_q - LEN_WIDTH'(1);
        end
    end

    // Read-back comparison results, held until the next accepted command.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mismatch_q <= '0;
            sig_q      <= '0;
        end else if (start_acc) begin
            mismatch_q <= '0;
            sig_q      <= '0;
        end else if (rsp_check) begin
            sig_q <= rotl1(sig_q) ^ tcdm.r_rdata_i;
            if ((tcdm.r_rdata_i != pattern_q) && (mismatch_q != '1)) begin
                mismatch_q <= mismatch_q + MISMATCH_WIDTH'(1);
            end
        end
    end

    // Sticky error: slave-reported error or a response nobody asked for.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (tcdm.r_valid_i && (tcdm.r_opc_i || outst_empty)) begin
            err_q <= 1'b1;
        end else if (start_acc) begin
            err_q <= 1'b0;
        end
    end

    assign tcdm.req_o   = req;
    assign tcdm.add_o   = add_q;
    assign tcdm.wen_o   = op_q;
    assign tcdm.be_o    = (state_q != ST_IDLE) ? '1 : '0;
    assign tcdm.wdata_o = (op_q == OP_FILL) ? pattern_q : '0;

    assign err_o          = err_q;
    assign mismatch_cnt_o = mismatch_q;
    assign signature_o    = sig_q;

endmodule
